// File: rtl/mio_responder.sv
// mio_responder: far end of the multicycle CPU's MIO bus.
// Serves one request at a time from a word-addressed RAM or a small IO
// space (LEDs, switches, reload timer). Each access takes WAIT_CYCLES
// wait states and then produces a one-cycle MIO_ready pulse. The timer's
// pending flag drives the CPU interrupt line.
module mio_responder #(
    parameter int         RAM_AW      = 10,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] IO_NIBBLE   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        INT,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    localparam int         RAM_WORDS = 1 << RAM_AW;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        accept;
    logic        commit;

    // Latched request; the byte-offset bits are not needed.
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic [31:0] din_q, din_d;
    logic        ready_q, ready_d;
    logic [15:0] led_q, led_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        pend_q, pend_d;

    logic [31:0] mem_q [RAM_WORDS];

    logic              is_io;
    logic [27:2]       io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       rdata_sel;
    logic              wr_ram, wr_led, wr_reload, wr_clear;
    logic              expire;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^Addr_out[1:0];

    // FSM state register and wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: accept in IDLE, count down wait states, one RESP cycle
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CPU_MIO) begin
                    accept  = 1'b1;
                    wcnt_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request only on the accepting edge so later bus changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= Addr_out[31:2];
            wdata_q <= Data_out;
            we_q    <= mem_w;
        end
    end

    assign is_io   = (addr_q[31:28] == IO_NIBBLE);
    assign io_off  = addr_q[27:2];
    assign ram_idx = addr_q[RAM_AW+1:2];

    assign wr_ram    = commit && we_q && !is_io;
    assign wr_led    = commit && we_q && is_io && (io_off == 26'd0);
    assign wr_reload = commit && we_q && is_io && (io_off == 26'd2);
    assign wr_clear  = commit && we_q && is_io && (io_off == 26'd3);

    // Read-data select from RAM or the IO registers
    always_comb begin
        rdata_sel = '0;
        if (!is_io) begin
            rdata_sel = mem_q[ram_idx];
        end else begin
            case (io_off)
                26'd0:   rdata_sel = {16'h0000, led_q};
                26'd1:   rdata_sel = {16'h0000, sw};
                26'd2:   rdata_sel = tcnt_q;
                26'd3:   rdata_sel = {31'd0, pend_q};
                default: rdata_sel = '0;
            endcase
        end
    end

    // RAM write port; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem_q[ram_idx] <= wdata_q;
        end
    end

    // Response and LED next values: both change only on the commit edge
    always_comb begin
        din_d   = din_q;
        ready_d = commit;
        led_d   = led_q;
        if (commit && !we_q) begin
            din_d = rdata_sel;
        end
        if (wr_led) begin
            led_d = wdata_q[15:0];
        end
    end

    assign expire = (reload_q != 32'd0) && (tcnt_q == 32'd0);

    // Timer: free-running reload counter; a bus write overrides the count and
    // an expiry beats a simultaneous clear of the pending flag
    always_comb begin
        reload_d = reload_q;
        tcnt_d   = tcnt_q;
        pend_d   = pend_q;
        if (reload_q != 32'd0) begin
            tcnt_d = expire ? reload_q : tcnt_q - 32'd1;
        end
        if (wr_reload) begin
            reload_d = wdata_q;
            tcnt_d   = wdata_q;
        end
        if (wr_clear && wdata_q[0]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    // Response, LED and timer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q    <= '0;
            ready_q  <= 1'b0;
            led_q    <= '0;
            reload_q <= '0;
            tcnt_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            din_q    <= din_d;
            ready_q  <= ready_d;
            led_q    <= led_d;
            reload_q <= reload_d;
            tcnt_q   <= tcnt_d;
            pend_q   <= pend_d;
        end
    end

    assign Data_in   = din_q;
    assign MIO_ready = ready_q;
    assign INT       = pend_q;
    assign led       = led_q;

endmodule
